audio_i2s_tx: RTL
=================

Name: audio_i2s_tx

Overview:
- Serializes 16-bit stereo PCM samples into a 4-wire I2S stream (MCLK, LRCK, SCK, SDIN) for the board's external audio DAC.
- Sits downstream of the tone/note generators, which present parallel `audio_left` / `audio_right` words.
- Latches one stereo sample per frame and emits a one-cycle `sample_req` so upstream logic can align sample updates to frame boundaries.

Parameters:
- DATA_W, 16, sample width in bits; must be ≤ 2^(FRAME_SHIFT-SCK_SHIFT-1)-1.
- MCLK_SHIFT, 2, MCLK period = 2^MCLK_SHIFT clk cycles (100 MHz → 25 MHz).
- SCK_SHIFT, 4, SCK period = 2^SCK_SHIFT clk cycles (6.25 MHz).
- FRAME_SHIFT, 10, LRCK period = 2^FRAME_SHIFT clk cycles (~97.7 kHz); 32 SCK slots per channel. Requires MCLK_SHIFT < SCK_SHIFT < FRAME_SHIFT.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- audio_left  input  DATA_W  left-channel sample, two's complement.
- audio_right  input  DATA_W  right-channel sample.
- mute  input  1  forces transmitted data to zero; sampled at the frame boundary.
- sample_req  output  1  one-cycle pulse when a new stereo sample is latched.
- audio_mclk  output  1  DAC master clock.
- audio_lrck  output  1  word select: 0 = left, 1 = right.
- audio_sck  output  1  serial bit clock.
- audio_sdin  output  1  serial data, MSB first.

Behaviour:
- Reset (rst_n=0, async):
  - cnt = 0; hold_l = hold_r = 0; mute_q = 0.
  - All outputs 0: sample_req, audio_sdin, audio_mclk, audio_sck, audio_lrck.
  - Asserting reset mid-frame aborts the frame; after release, the stream restarts at cnt = 0 as the left half.
- cnt: FRAME_SHIFT-bit free-running counter, +1 every clk; wraps from all-ones to 0.
- Clock outputs, each a direct register bit (glitch-free):
  - audio_mclk = cnt[MCLK_SHIFT-1]
  - audio_sck = cnt[SCK_SHIFT-1]
  - audio_lrck = cnt[FRAME_SHIFT-1]
- Frame boundary, on the cycle where cnt == all-ones:
  - hold_l <= audio_left; hold_r <= audio_right; mute_q <= mute.
  - sample_req = 1 for exactly that cycle (registered, so visible the following cycle, i.e. cnt == 0).
  - Inputs may change at any other time without effect.
- Slot index s = cnt[FRAME_SHIFT-2:SCK_SHIFT], range 0..31 within each half. Half h = cnt[FRAME_SHIFT-1].
- Data launch:
  - audio_sdin is registered and updates only on the clk edge where cnt[SCK_SHIFT-1:0] == all-ones, i.e. coincident with the SCK falling edge.
  - The value loaded is for the slot that begins on the next cycle, so SDIN is stable for a full SCK period around every SCK rising edge.
- Bit mapping (standard I2S): slot s carries bit DATA_W-s of the active hold register for 1 ≤ s ≤ DATA_W; all other slots carry 0.
  - The MSB therefore appears one SCK after each LRCK edge.
- Mute: if mute_q = 1, audio_sdin = 0 for the entire frame; clocks are unaffected.
- Frame latency: a sample latched at frame boundary n is transmitted during frame n+1. With 100 MHz clk, sample → MSB on wire takes 1 + 16 clk cycles.

Optional Feature:
- Macro: I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. Slot s carries bit DATA_W-1-s for 0 ≤ s < DATA_W; the MSB is coincident with the LRCK edge.
- Undefined: standard I2S mapping as above (1-SCK MSB delay).
- Clocks, latching and sample_req are identical in both builds.

Decomposition:
- Package `audio_pkg`: DATA_W default, the shift constants, LRCK_LEFT / LRCK_RIGHT encodings, SILENCE = 16'h0000.
- Sub-module `audio_clk_div`: owns cnt and produces mclk/sck/lrck, plus strobes for frame_end (cnt all-ones) and sck_fall (cnt low bits all-ones).
- audio_i2s_tx owns the hold registers, mute_q, bit selection and sample_req.

Test Plan:
- Reset release → audio_mclk toggles every 2 clk, audio_sck every 8 clk, audio_lrck every 512 clk; first audio_lrck rise at cnt = 512.
- audio_left = 16'h77D0, audio_right = 16'h882F, held constant; decode frame 2 by sampling SDIN on SCK rising edges:
  - Left slots 1..16 = 0111_0111_1101_0000; right slots 1..16 = 1000_1000_0010_1111.
  - Slots 0 and 17..31 = 0.
- sample_req → exactly one pulse per 1024 clk, at cnt = 0. Changing audio_left at cnt = 300 does not alter the current frame's bits; the new value appears in the next frame.
- mute = 1 asserted mid-frame with samples 16'hFFFF → current frame still transmits 16'hFFFF; next frame SDIN is all-zero; clocks are unchanged.
- rst_n pulsed low at cnt = 700 → all outputs 0 asynchronously; after release, cnt restarts at 0 and the first frame's SDIN is all-zero (hold registers cleared).
- Build with I2S_LEFT_JUSTIFIED_EN, left = 16'h8001 → slot 0 = 1, slots 1..14 = 0, slot 15 = 1, slots 16..31 = 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the I2S transmit path.
// Clock-divider shifts, LRCK encoding and the silence word.
package audio_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int MCLK_SHIFT_DEF  = 2;
  localparam int SCK_SHIFT_DEF   = 4;
  localparam int FRAME_SHIFT_DEF = 10;

  typedef enum logic {
    LRCK_LEFT  = 1'b0,
    LRCK_RIGHT = 1'b1
  } lrck_e;

  localparam logic [DATA_W_DEF-1:0] SILENCE = 16'h0000;

endpackage

// File: rtl/audio_clk_div.sv
// Free-running frame counter producing MCLK/SCK/LRCK and
// the frame_end / sck_fall strobes plus the upcoming slot.
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int MCLK_SHIFT  = MCLK_SHIFT_DEF,
  parameter int SCK_SHIFT   = SCK_SHIFT_DEF,
  parameter int FRAME_SHIFT = FRAME_SHIFT_DEF,
  parameter int SLOT_W      = FRAME_SHIFT - SCK_SHIFT - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic              frame_end,
  output logic              sck_fall,
  output logic [SLOT_W-1:0] slot_nxt,
  output lrck_e             half_nxt
);

  logic [FRAME_SHIFT-1:0] cnt;
  logic [FRAME_SHIFT-1:0] cnt_nxt;

  assign cnt_nxt = cnt + FRAME_SHIFT'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  // Clocks are plain register bits, so they cannot glitch.
  assign mclk = cnt[MCLK_SHIFT-1];
  assign sck  = cnt[SCK_SHIFT-1];
  assign lrck = cnt[FRAME_SHIFT-1];

  assign frame_end = &cnt;
  assign sck_fall  = &cnt[SCK_SHIFT-1:0];

  assign slot_nxt = cnt_nxt[FRAME_SHIFT-2:SCK_SHIFT];
  assign half_nxt = lrck_e'(cnt_nxt[FRAME_SHIFT-1]);

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo PCM to I2S serializer for the external DAC.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MCLK_SHIFT  = MCLK_SHIFT_DEF,
  parameter int SCK_SHIFT   = SCK_SHIFT_DEF,
  parameter int FRAME_SHIFT = FRAME_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] audio_left,
  input  logic [DATA_W-1:0] audio_right,
  input  logic              mute,
  output logic              sample_req,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic              audio_sdin
);

  localparam int SLOT_W = FRAME_SHIFT - SCK_SHIFT - 1;

  logic              frame_end;
  logic              sck_fall;
  logic [SLOT_W-1:0] slot_nxt;
  lrck_e             half_nxt;

  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic              mute_q;
  logic [DATA_W-1:0] word_nxt;
  logic              mute_nxt;
  logic              bit_nxt;

  audio_clk_div #(
    .MCLK_SHIFT  (MCLK_SHIFT),
    .SCK_SHIFT   (SCK_SHIFT),
    .FRAME_SHIFT (FRAME_SHIFT),
    .SLOT_W      (SLOT_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .mclk      (audio_mclk),
    .sck       (audio_sck),
    .lrck      (audio_lrck),
    .frame_end (frame_end),
    .sck_fall  (sck_fall),
    .slot_nxt  (slot_nxt),
    .half_nxt  (half_nxt)
  );

  // At the frame boundary the hold regs load on the same edge
  // that launches slot 0, so bypass the incoming values.
  always_comb begin
    mute_nxt = frame_end ? mute : mute_q;
    word_nxt = frame_end ? audio_left : hold_l;
    if (half_nxt == LRCK_RIGHT)
      word_nxt = hold_r;
  end

  always_comb begin
    bit_nxt = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
      if (int'(slot_nxt) == DATA_W - 1 - i)
        bit_nxt = word_nxt[i];
`else
      if (int'(slot_nxt) == DATA_W - i)
        bit_nxt = word_nxt[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l     <= DATA_W'(SILENCE);
      hold_r     <= DATA_W'(SILENCE);
      mute_q     <= 1'b0;
      sample_req <= 1'b0;
      audio_sdin <= 1'b0;
    end else begin
      sample_req <= frame_end;
      if (frame_end) begin
        hold_l <= audio_left;
        hold_r <= audio_right;
        mute_q <= mute;
      end
      if (sck_fall)
        audio_sdin <= bit_nxt & ~mute_nxt;
    end
  end

endmodule
